// File: rtl/morse_char_decoder_if.sv
// Character stream from the Morse decoder to the display/UART side.
// The decoder drives valid/char; the consumer drives ready.
interface morse_char_decoder_if;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_char;

   modport master (
      output out_valid,
      output out_char,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_char,
      output out_ready
   );
endinterface

// File: rtl/morse_char_decoder.sv
// Morse key levels to uppercase ASCII, buffered in a FWFT FIFO.
// Define MORSE_DIGITS_EN for 5-symbol digit codes (0-9).
module morse_char_decoder #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [7:0]  ERR_CHAR   = 8'h3F
) (
   input  logic clk,
   input  logic rst,
   input  logic dot_inp,
   input  logic dash_inp,
   input  logic char_space_inp,
   input  logic word_space_inp,
   morse_char_decoder_if.master out_if,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
   output logic overflow
);

`ifdef MORSE_DIGITS_EN
   localparam int unsigned MAXLEN = 5;
`else
   localparam int unsigned MAXLEN = 4;
`endif
   localparam int unsigned CW = $clog2(FIFO_DEPTH+1);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam logic [2:0] LEN_MAX = 3'(MAXLEN);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      SPACE
   } state_t;

   logic [3:0]        key_q;
   logic [3:0]        key_prev;
   logic [3:0]        rise;
   logic              ev_dot;
   logic              ev_dash;
   logic              ev_cs;
   logic              ev_ws;
   logic              ev_sym;
   state_t            state;
   state_t            state_nx;
   logic [2:0]        len;
   logic [MAXLEN-1:0] code;
   logic [4:0]        code5;
   logic              err;
   logic              sym_start;
   logic              sym_append;
   logic              push_req;
   logic [7:0]        push_char;
   logic [7:0]        dec_char;
   logic [7:0]        mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              last_space;
   logic              full;
   logic              pop;
   logic              push_ok;

   // Register key levels; history loads 1 so held keys need a re-press.
   always_ff @(posedge clk) begin
      if (!rst) begin
         key_q    <= '1;
         key_prev <= '1;
      end else begin
         key_q    <= {word_space_inp, char_space_inp, dash_inp, dot_inp};
         key_prev <= key_q;
      end
   end

   assign rise    = key_q & ~key_prev;
   assign ev_ws   = rise[3];
   assign ev_cs   = rise[2] & ~rise[3];
   assign ev_dash = rise[1] & ~(|rise[3:2]);
   assign ev_dot  = rise[0] & ~(|rise[3:1]);
   assign ev_sym  = ev_dot | ev_dash;

   // Symbol store: first symbol lands in the MSB of the len-bit code.
   always_ff @(posedge clk) begin
      if (!rst) begin
         len  <= '0;
         code <= '0;
         err  <= 1'b0;
      end else if (sym_start) begin
         len  <= 3'd1;
         code <= {{(MAXLEN-1){1'b0}}, ev_dash};
         err  <= 1'b0;
      end else if (sym_append) begin
         if (len == LEN_MAX) begin
            err <= 1'b1;
         end else begin
            len  <= len + 3'd1;
            code <= {code[MAXLEN-2:0], ev_dash};
         end
      end
   end

   // International Morse lookup keyed on {len, right-justified code}.
   always_comb begin
      code5    = 5'(code);
      dec_char = ERR_CHAR;
      case ({len, code5})
         8'b001_00000: dec_char = 8'h45;
         8'b001_00001: dec_char = 8'h54;
         8'b010_00001: dec_char = 8'h41;
         8'b010_00000: dec_char = 8'h49;
         8'b010_00011: dec_char = 8'h4D;
         8'b010_00010: dec_char = 8'h4E;
         8'b011_00100: dec_char = 8'h44;
         8'b011_00110: dec_char = 8'h47;
         8'b011_00101: dec_char = 8'h4B;
         8'b011_00111: dec_char = 8'h4F;
         8'b011_00010: dec_char = 8'h52;
         8'b011_00000: dec_char = 8'h53;
         8'b011_00001: dec_char = 8'h55;
         8'b011_00011: dec_char = 8'h57;
         8'b100_01000: dec_char = 8'h42;
         8'b100_01010: dec_char = 8'h43;
         8'b100_00010: dec_char = 8'h46;
         8'b100_00000: dec_char = 8'h48;
         8'b100_00111: dec_char = 8'h4A;
         8'b100_00100: dec_char = 8'h4C;
         8'b100_00110: dec_char = 8'h50;
         8'b100_01101: dec_char = 8'h51;
         8'b100_00001: dec_char = 8'h56;
         8'b100_01001: dec_char = 8'h58;
         8'b100_01011: dec_char = 8'h59;
         8'b100_01100: dec_char = 8'h5A;
`ifdef MORSE_DIGITS_EN
         8'b101_11111: dec_char = 8'h30;
         8'b101_01111: dec_char = 8'h31;
         8'b101_00111: dec_char = 8'h32;
         8'b101_00011: dec_char = 8'h33;
         8'b101_00001: dec_char = 8'h34;
         8'b101_00000: dec_char = 8'h35;
         8'b101_10000: dec_char = 8'h36;
         8'b101_11000: dec_char = 8'h37;
         8'b101_11100: dec_char = 8'h38;
         8'b101_11110: dec_char = 8'h39;
`endif
         default:      dec_char = ERR_CHAR;
      endcase
      if (err) begin
         dec_char = ERR_CHAR;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // FSM next state.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (ev_sym) state_nx = COLLECT;
         end
         COLLECT: begin
            if (ev_ws) state_nx = SPACE;
            else if (ev_cs) state_nx = IDLE;
         end
         SPACE:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // FSM outputs: symbol-store control and FIFO push requests.
   always_comb begin
      sym_start  = 1'b0;
      sym_append = 1'b0;
      push_req   = 1'b0;
      push_char  = 8'h00;
      unique case (state)
         IDLE: begin
            sym_start = ev_sym;
            if (ev_ws && !last_space) begin
               push_req  = 1'b1;
               push_char = 8'h20;
            end
         end
         COLLECT: begin
            sym_append = ev_sym;
            if (ev_ws || ev_cs) begin
               push_req  = 1'b1;
               push_char = dec_char;
            end
         end
         SPACE: begin
            push_req  = 1'b1;
            push_char = 8'h20;
         end
         default: begin
            push_req = 1'b0;
         end
      endcase
   end

   assign full    = (fifo_count == CW'(FIFO_DEPTH));
   assign pop     = out_if.out_valid & out_if.out_ready;
   assign push_ok = push_req & (~full | pop);

   // FIFO storage; slots clear on reset so the idle head reads 0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem[i] <= 8'h00;
         end
      end else if (push_ok) begin
         mem[wr_ptr] <= push_char;
      end
   end

   // FIFO pointers, occupancy, sticky overflow and last-space memory.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
         last_space <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr     <= wr_ptr + 1'b1;
            last_space <= (push_char == 8'h20);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push_req && full && !pop) begin
            overflow <= 1'b1;
         end
         case ({push_ok, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   assign out_if.out_valid = (fifo_count != '0);
   assign out_if.out_char  = mem[rd_ptr];

endmodule

// File: tb/tb_morse_char_decoder.sv
// Bench for morse_char_decoder: string-table Morse model with a
// character queue, checked every cycle, plus directed literal checks.
module tb_morse_char_decoder;
   localparam int DEPTH = 4;
`ifdef MORSE_DIGITS_EN
   localparam int MAXLEN = 5;
   localparam int NT     = 36;
`else
   localparam int MAXLEN = 4;
   localparam int NT     = 26;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       dot, dash, cs, ws;
   logic [2:0] fifo_count;
   logic       overflow;

   morse_char_decoder_if bus ();

   morse_char_decoder #(.FIFO_DEPTH(DEPTH), .ERR_CHAR(8'h3F)) dut (
      .clk            (clk),
      .rst            (rst),
      .dot_inp        (dot),
      .dash_inp       (dash),
      .char_space_inp (cs),
      .word_space_inp (ws),
      .out_if         (bus.master),
      .fifo_count     (fifo_count),
      .overflow       (overflow)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endfunction

   // ---------------- model ----------------
   string tbl [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.",
      "....", "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
      "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-", "-.--",
      "--..", "-----", ".----", "..---", "...--", "....-", ".....",
      "-....", "--...", "---..", "----."};

   logic [7:0] m_q [$];
   bit         m_ovf, m_last_sp, m_coll, m_err, m_sp_next;
   string      m_sym;
   int         m_pend;
   logic [3:0] m_prev;
   logic [7:0] got [$];

   function automatic logic [7:0] m_decode();
      if (m_err) return 8'h3F;
      for (int i = 0; i < NT; i++) begin
         if (tbl[i] == m_sym) begin
            if (i < 26) return 8'(8'h41 + i);
            else return 8'(8'h30 + i - 26);
         end
      end
      return 8'h3F;
   endfunction

   function automatic void m_push(logic [7:0] c);
      if (m_q.size() < DEPTH) begin
         m_q.push_back(c);
         m_last_sp = (c == 8'h20);
      end else begin
         m_ovf = 1'b1;
      end
   endfunction

   always @(posedge clk) begin
      logic [3:0] cur, r;
      string s;
      if (!rst) begin
         m_q.delete();
         m_ovf = 0; m_last_sp = 0; m_coll = 0; m_err = 0;
         m_sp_next = 0; m_sym = ""; m_pend = 0; m_prev = 4'hF;
      end else begin
         if (m_q.size() != 0 && bus.out_ready) void'(m_q.pop_front());
         if (m_sp_next) begin
            m_push(8'h20);
            m_sp_next = 0;
         end else if (m_pend == 1 || m_pend == 2) begin
            s = (m_pend == 2) ? "-" : ".";
            if (!m_coll) begin
               m_coll = 1; m_sym = s; m_err = 0;
            end else if (m_sym.len() >= MAXLEN) begin
               m_err = 1;
            end else begin
               m_sym = {m_sym, s};
            end
         end else if (m_pend == 3) begin
            if (m_coll) begin
               m_push(m_decode());
               m_coll = 0;
            end
         end else if (m_pend == 4) begin
            if (m_coll) begin
               m_push(m_decode());
               m_coll = 0;
               m_sp_next = 1;
            end else if (!m_last_sp) begin
               m_push(8'h20);
            end
         end
         cur = {ws, cs, dash, dot};
         r = cur & ~m_prev;
         m_prev = cur;
         m_pend = r[3] ? 4 : r[2] ? 3 : r[1] ? 2 : r[0] ? 1 : 0;
      end
   end

   // Compare every cycle and log accepted characters.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         chk("valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
         chk("count", 32'(fifo_count), 32'(m_q.size()));
         chk("ovf", 32'(overflow), 32'(m_ovf));
         if (m_q.size() != 0) chk("char", 32'(bus.out_char), 32'(m_q[0]));
         if (bus.out_valid && bus.out_ready) got.push_back(bus.out_char);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(int n);
      repeat (n) step();
   endtask

   task automatic key(logic [3:0] m);
      step();
      {ws, cs, dash, dot} = m;
      step();
      step();
      {ws, cs, dash, dot} = 4'b0;
      step();
      step();
   endtask

   task automatic chk_got(string nm, int n, logic [39:0] e);
      chk({nm, "_n"}, 32'(got.size()), 32'(n));
      for (int i = 0; i < n && i < got.size(); i++) begin
         chk(nm, 32'(got[i]), 32'(e[39-8*i -: 8]));
      end
      got.delete();
   endtask

   localparam logic [3:0] K_DOT = 4'b0001, K_DASH = 4'b0010;
   localparam logic [3:0] K_CS = 4'b0100, K_WS = 4'b1000;

   initial begin
      rst = 0; dot = 0; dash = 0; cs = 0; ws = 0;
      bus.out_ready = 1;
      idle(3);
      rst = 1;
      step();
      chk("rst_valid", 32'(bus.out_valid), 0);
      chk("rst_char", 32'(bus.out_char), 0);
      chk("rst_count", 32'(fifo_count), 0);
      chk("rst_ovf", 32'(overflow), 0);

      // 'A' with latency check
      key(K_DOT);
      key(K_DASH);
      step();
      cs = 1;
      @(posedge clk); #1;
      chk("t1_lat_k", 32'(bus.out_valid), 0);
      @(posedge clk); #1;
      chk("t1_lat_k1", 32'(bus.out_valid), 1);
      chk("t1_char", 32'(bus.out_char), 32'h41);
      step();
      cs = 0;
      idle(4);
      chk_got("t1", 1, {8'h41, 32'h0});

      // 'B', space, no double space
      key(K_DASH); key(K_DOT); key(K_DOT); key(K_DOT);
      key(K_WS); key(K_WS);
      idle(4);
      chk_got("t2", 2, {8'h42, 8'h20, 24'h0});

      // five dots
      repeat (5) key(K_DOT);
      key(K_CS);
      idle(4);
`ifdef MORSE_DIGITS_EN
      chk_got("t3", 1, {8'h35, 32'h0});
`else
      chk_got("t3", 1, {8'h3F, 32'h0});
`endif

      // overflow
      step();
      bus.out_ready = 0;
      repeat (5) begin
         key(K_DOT);
         key(K_CS);
      end
      idle(2);
      chk("t4_count", 32'(fifo_count), 4);
      chk("t4_ovf", 32'(overflow), 1);
      step();
      bus.out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t4_drain_v", 32'(bus.out_valid), 1);
         chk("t4_drain_c", 32'(bus.out_char), 32'h45);
      end
      @(negedge clk);
      chk("t4_empty", 32'(bus.out_valid), 0);
      chk("t4_ovf_stay", 32'(overflow), 1);
      idle(2);
      chk_got("t4", 4, {8'h45, 8'h45, 8'h45, 8'h45, 8'h0});

      // same-cycle dot+dash -> dash wins
      key(K_DOT | K_DASH);
      key(K_CS);
      idle(4);
      chk_got("t5a", 1, {8'h54, 32'h0});

      // reset mid-character
      key(K_DASH); key(K_DASH);
      step();
      rst = 0;
      step();
      rst = 1;
      key(K_CS);
      idle(4);
      chk_got("t5b", 0, 40'h0);
      chk("t5_ovf_clr", 32'(overflow), 0);

      // unlisted code
      key(K_DOT); key(K_DOT); key(K_DASH); key(K_DASH); key(K_CS);
      idle(4);
      chk_got("t6a", 1, {8'h3F, 32'h0});

      // full FIFO with simultaneous push and pop
      step();
      bus.out_ready = 0;
      key(K_DOT); key(K_CS);
      key(K_DASH); key(K_CS);
      key(K_DOT); key(K_DOT); key(K_CS);
      key(K_DASH); key(K_DASH); key(K_CS);
      idle(2);
      chk("t6_full", 32'(fifo_count), 4);
      key(K_DOT); key(K_DASH);
      step();
      cs = 1;
      step();
      bus.out_ready = 1;
      step();
      bus.out_ready = 0;
      cs = 0;
      @(negedge clk);
      chk("t6_count", 32'(fifo_count), 4);
      chk("t6_ovf", 32'(overflow), 0);
      idle(2);
      bus.out_ready = 1;
      idle(8);
      chk_got("t6b", 5, {8'h45, 8'h54, 8'h49, 8'h4D, 8'h41});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
